// File: rtl/send_pkg.sv
// send_pkg: shared widths, header field layout and FSM encoding for the
// per-port packet generator.
//
// Header word layout (LSB first): dest | prio | length | tx_port (16 bits),
// zero-padded at the MSB up to the data width.
package send_pkg;

  // Width of the tx_port field carried in the header beat.
  localparam int WIDTH_HAND = 16;

  // Widths for the default switch geometry (16 ports, 512 beats, 8 levels).
  localparam int WIDTH_SEL      = $clog2(16);
  localparam int WIDTH_LENGTH   = $clog2(512);
  localparam int WIDTH_PRIORITY = $clog2(8);

  // Header field LSB offsets, derived from the actual field widths.
  function automatic int hdr_dest_lsb();
    return 0;
  endfunction

  function automatic int hdr_prio_lsb(input int sel_w);
    return sel_w;
  endfunction

  function automatic int hdr_len_lsb(input int sel_w, input int prio_w);
    return sel_w + prio_w;
  endfunction

  function automatic int hdr_port_lsb(input int sel_w, input int prio_w, input int len_w);
    return sel_w + prio_w + len_w;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOP  = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_EOP  = 3'd4
  } send_state_e;

endpackage

// File: rtl/send_payload_gen.sv
// send_payload_gen: payload beat counter and deterministic data pattern.
//
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clr         - return the counter to beat 0
//   inc         - the current beat is being emitted; advance to the next one
//   length      - latched payload beat count L
//   data        - pattern for the current beat: k ^ (tx_port << (DATA_WIDTH-WIDTH_SEL))
//   last        - current beat is the final one (L-1, or beat 0 when L is 0)
module send_payload_gen
  import send_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int WIDTH_SEL    = 4,
  parameter int WIDTH_LENGTH = 9,
  parameter int tx_port      = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    inc,
  input  logic [WIDTH_LENGTH-1:0] length,
  output logic [DATA_WIDTH-1:0]   data,
  output logic                    last
);

  localparam logic [DATA_WIDTH-1:0] PORT_PAT =
    DATA_WIDTH'(tx_port) << (DATA_WIDTH - WIDTH_SEL);

  logic [WIDTH_LENGTH-1:0] cnt;

  // L = 0 still yields one beat when the payload state is entered directly.
  assign last = (length == '0) || (cnt == (length - WIDTH_LENGTH'(1)));
  assign data = DATA_WIDTH'(cnt) ^ PORT_PAT;

  // Holding at the last beat keeps the counter from wrapping mid-packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + WIDTH_LENGTH'(1);
    end
  end

endmodule

// File: rtl/packet_send_module.sv
// packet_send_module: per-port packet generator for one switch ingress port.
// On an accepted start it emits SOP, an optional header beat, L payload
// beats and EOP/done, then returns to ready.
//
// Build option: SEND_HEADER_EN - when defined, a header beat
// {tx_port, length, prio, dest} follows SOP; otherwise payload follows SOP
// directly and a zero-length request still sends one payload beat.
//
// Ports:
//   clk, rst_n             - clock, async active-low reset
//   start                  - send request, sampled only while ready
//   dest, prio, length     - packet fields, latched on an accepted start
//   ready                  - idle, can accept start
//   done                   - one-cycle completion pulse (with wr_eop)
//   wr_sop, wr_eop         - framing pulses
//   wr_vld, wr_data        - beat valid and data (data is 0 when not valid)
//
// state | meaning
// IDLE  | waiting for start, ready=1
// SOP   | wr_sop pulse
// HDR   | header beat (SEND_HEADER_EN only)
// PAY   | payload beats 0..L-1
// EOP   | wr_eop and done pulse
module packet_send_module
  import send_pkg::*;
#(
  parameter int PORT_NUB_TOTAL  = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_LENGTH_MAX = 512,
  parameter int PRIORITY        = 8,
  parameter int tx_port         = 0,
  localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL),
  localparam int WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX),
  localparam int WIDTH_PRIORITY = $clog2(PRIORITY)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH_SEL-1:0]      dest,
  input  logic [WIDTH_PRIORITY-1:0] prio,
  input  logic [WIDTH_LENGTH-1:0]   length,
  output logic                      ready,
  output logic                      done,
  output logic                      wr_sop,
  output logic                      wr_eop,
  output logic                      wr_vld,
  output logic [DATA_WIDTH-1:0]     wr_data
);

  if (WIDTH_HAND + WIDTH_LENGTH + WIDTH_PRIORITY + WIDTH_SEL > DATA_WIDTH) begin : g_width_chk
    $error("packet_send_module: header fields do not fit in DATA_WIDTH");
  end

  send_state_e state_q, state_d;

  logic [WIDTH_SEL-1:0]      dest_q;
  logic [WIDTH_PRIORITY-1:0] prio_q;
  logic [WIDTH_LENGTH-1:0]   len_q;
  logic                      last_q;
  logic                      latch;

  logic                  gen_clr;
  logic                  gen_inc;
  logic [DATA_WIDTH-1:0] gen_data;
  logic                  gen_last;

  logic                  sop_d, eop_d, vld_d, done_d;
  logic [DATA_WIDTH-1:0] data_d;

  assign ready = (state_q == ST_IDLE);

  send_payload_gen #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WIDTH_SEL   (WIDTH_SEL),
    .WIDTH_LENGTH(WIDTH_LENGTH),
    .tx_port     (tx_port)
  ) u_payload (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (gen_clr),
    .inc   (gen_inc),
    .length(len_q),
    .data  (gen_data),
    .last  (gen_last)
  );

`ifdef SEND_HEADER_EN
  logic [DATA_WIDTH-1:0] hdr_word;

  always_comb begin
    hdr_word = '0;
    hdr_word[hdr_dest_lsb() +: WIDTH_SEL] = dest_q;
    hdr_word[hdr_prio_lsb(WIDTH_SEL) +: WIDTH_PRIORITY] = prio_q;
    hdr_word[hdr_len_lsb(WIDTH_SEL, WIDTH_PRIORITY) +: WIDTH_LENGTH] = len_q;
    hdr_word[hdr_port_lsb(WIDTH_SEL, WIDTH_PRIORITY, WIDTH_LENGTH) +: WIDTH_HAND] =
      WIDTH_HAND'(tx_port);
  end
`else
  // Without a header beat nothing consumes the latched dest/prio.
  logic unused_hdr_fields;
  assign unused_hdr_fields = ^{dest_q, prio_q};
`endif

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SOP;
          latch   = 1'b1;
        end
      end
`ifdef SEND_HEADER_EN
      ST_SOP:  state_d = ST_HDR;
      ST_HDR:  state_d = (len_q == '0) ? ST_EOP : ST_PAY;
`else
      ST_SOP:  state_d = ST_PAY;
`endif
      // last_q marks that the beat now on the bus was the final one.
      ST_PAY:  state_d = last_q ? ST_EOP : ST_PAY;
      ST_EOP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state they describe.
  always_comb begin
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    data_d  = '0;
    gen_inc = 1'b0;
    gen_clr = (state_q == ST_IDLE);
    case (state_d)
      ST_SOP: sop_d = 1'b1;
`ifdef SEND_HEADER_EN
      ST_HDR: begin
        vld_d  = 1'b1;
        data_d = hdr_word;
      end
`endif
      ST_PAY: begin
        vld_d   = 1'b1;
        data_d  = gen_data;
        gen_inc = 1'b1;
      end
      ST_EOP: begin
        eop_d  = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      prio_q  <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      wr_sop  <= 1'b0;
      wr_eop  <= 1'b0;
      wr_vld  <= 1'b0;
      done    <= 1'b0;
      wr_data <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        dest_q <= dest;
        prio_q <= prio;
        len_q  <= length;
      end
      if (state_q == ST_IDLE) begin
        last_q <= 1'b0;
      end else if (gen_inc) begin
        last_q <= gen_last;
      end
      wr_sop  <= sop_d;
      wr_eop  <= eop_d;
      wr_vld  <= vld_d;
      done    <= done_d;
      wr_data <= data_d;
    end
  end

endmodule

// File: tb/tb_packet_send_module.sv
module tb_packet_send_module;

  localparam int TXP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  dest = '0;
  logic [2:0]  prio = '0;
  logic [8:0]  length = '0;
  logic        ready, done, wr_sop, wr_eop, wr_vld;
  logic [31:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;

  packet_send_module #(
    .PORT_NUB_TOTAL (16),
    .DATA_WIDTH     (32),
    .DATA_LENGTH_MAX(512),
    .PRIORITY       (8),
    .tx_port        (TXP)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .dest   (dest),
    .prio   (prio),
    .length (length),
    .ready  (ready),
    .done   (done),
    .wr_sop (wr_sop),
    .wr_eop (wr_eop),
    .wr_vld (wr_vld),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // {ready, wr_sop, wr_eop, wr_vld, done, wr_data}
  wire [36:0] obs = {ready, wr_sop, wr_eop, wr_vld, done, wr_data};

  localparam logic [4:0] F_IDLE = 5'b10000;
  localparam logic [4:0] F_SOP  = 5'b01000;
  localparam logic [4:0] F_BEAT = 5'b00010;
  localparam logic [4:0] F_EOP  = 5'b00101;

`ifdef SEND_HEADER_EN
  localparam int HOFF = 1;
`else
  localparam int HOFF = 0;
`endif

  task automatic chk(input string tag, input logic [36:0] o, input logic [36:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Sends one packet and checks every cycle from SOP to the return to idle.
  // disturb: hold start high and change all fields for the whole packet.
  task automatic pkt(input logic [3:0] d, input logic [2:0] p, input logic [8:0] l,
                     input bit disturb);
    int nb;
    logic [31:0] h;
    h  = {16'(TXP), l, p, d};
    nb = int'(l);
`ifndef SEND_HEADER_EN
    if (l == 9'd0) nb = 1;
`endif
    @(negedge clk);
    chk("pre_ready", obs, {F_IDLE, 32'h0});
    start = 1'b1; dest = d; prio = p; length = l;
    @(negedge clk);
    start = 1'b0;
    chk("sop", obs, {F_SOP, 32'h0});
    if (disturb) begin
      start = 1'b1; dest = ~d; prio = ~p; length = l + 9'd3;
    end
`ifdef SEND_HEADER_EN
    @(negedge clk);
    chk("hdr", obs, {F_BEAT, h});
`endif
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      chk($sformatf("pay%0d", k), obs, {F_BEAT, 32'h2000_0000 | 32'(k)});
    end
    @(negedge clk);
    chk("eop", obs, {F_EOP, 32'h0});
    start = 1'b0;
    @(negedge clk);
    chk("post_idle", obs, {F_IDLE, 32'h0});
    if (disturb) begin
      repeat (5) begin
        @(negedge clk);
        chk("no_second_pkt", obs, {F_IDLE, 32'h0});
      end
    end
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1 chk("in_reset", obs, {F_IDLE, 32'h0});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", obs, {F_IDLE, 32'h0});
    end

    // Main packet: header 0x0002_0815, payload 0x2000_0000..0x2000_000F.
    pkt(4'd5, 3'd1, 9'd16, 1'b0);
    // Zero length.
    pkt(4'd3, 3'd7, 9'd0, 1'b0);
    // Single beat, max field values.
    pkt(4'd15, 3'd7, 9'd1, 1'b0);
    // start and fields disturbed while the packet is in flight.
    pkt(4'd9, 3'd2, 9'd3, 1'b1);

    // Reset during payload.
    @(negedge clk);
    start = 1'b1; dest = 4'd6; prio = 3'd3; length = 9'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pay_before_rst", obs, {F_BEAT, 32'h2000_0000 | 32'(2 - HOFF)});
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_pay", obs, {F_IDLE, 32'h0});
    @(negedge clk);
    chk("rst_hold", obs, {F_IDLE, 32'h0});
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after_rst_idle", obs, {F_IDLE, 32'h0});
    end
    pkt(4'd12, 3'd4, 9'd20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
